// File: rtl/mem_sync_wait.sv
// Clocked main memory with EN/RW/MFC handshake, programmable wait states,
// out-of-range / boot-protect error flag and boot program reload on reset.
module mem_sync_wait #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned WAIT_CYCLES  = 2,
  parameter bit          BOOT_PROTECT = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              RW,
  input  logic [ADDR_W-1:0] MAR_to_MEM,
  input  logic [DATA_W-1:0] MDR_to_MEM,
  output logic [DATA_W-1:0] MEM_to_MDR,
  output logic              MFC,
  output logic              ERR
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int unsigned AW1   = ADDR_W + 1;

  // One extra bit so DEPTH == 2^ADDR_W still compares correctly
  localparam logic [ADDR_W:0] DEPTH_LIM = AW1'(DEPTH);
  localparam logic [ADDR_W:0] BOOT_LIM  = AW1'(8);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              complete_c;
  logic              in_range_c;
  logic              protect_c;
  logic              wr_ok_c;
  logic [IDX_W-1:0]  idx_c;

  assign in_range_c = ({1'b0, addr_q} < DEPTH_LIM);
  assign protect_c  = BOOT_PROTECT && ({1'b0, addr_q} < BOOT_LIM);
  assign wr_ok_c    = in_range_c && !protect_c;
  assign idx_c      = addr_q[IDX_W-1:0];

  // Next-state logic; completion fires on the BUSY edge where the counter is exhausted
  always_comb begin
    state_d    = state_q;
    complete_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (EN) state_d = S_BUSY;
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          complete_c = 1'b1;
          state_d    = EN ? S_DONE : S_IDLE;
        end
      end
      S_DONE: begin
        if (!EN) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control, capture and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      MEM_to_MDR <= '0;
      MFC        <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && EN) begin
        rw_q   <= RW;
        addr_q <= MAR_to_MEM;
        data_q <= MDR_to_MEM;
        cnt_q  <= CNT_W'(WAIT_CYCLES);
      end
      if (state_q == S_BUSY && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (complete_c) begin
        MFC <= EN;
        if (rw_q) begin
          MEM_to_MDR <= in_range_c ? mem[idx_c] : '0;
          ERR        <= !in_range_c;
        end else begin
          ERR <= !wr_ok_c;
        end
      end
      if (state_q == S_DONE && !EN) begin
        MFC <= 1'b0;
      end
    end
  end

  // Storage: boot words reloaded on reset, which also blocks any in-flight write
  always_ff @(posedge CLK) begin
    if (RST) begin
      mem[0] <= DATA_W'(16'h7002);
      mem[1] <= DATA_W'(16'hF0FF);
      mem[2] <= DATA_W'(16'h1043);
      mem[3] <= DATA_W'(16'h5047);
      mem[4] <= DATA_W'(16'h9043);
      mem[5] <= DATA_W'(16'h607F);
      mem[6] <= DATA_W'(16'hD0C1);
      mem[7] <= DATA_W'(16'hC042);
    end else if (complete_c && !rw_q && wr_ok_c) begin
      mem[idx_c] <= data_q;
    end
  end

endmodule

// File: tb/tb_mem_sync_wait.sv
// Directed bench driving three memory variants from shared stimulus:
// a: 2 wait states, b: 0 wait states, c: 2 wait states with boot protect.
module tb_mem_sync_wait;

  logic        clk;
  logic        rst;
  logic        en;
  logic        rw;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata_a, rdata_b, rdata_c;
  logic        mfc_a, mfc_b, mfc_c;
  logic        err_a, err_b, err_c;

  int checks = 0;
  int errors = 0;

  mem_sync_wait #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(2), .BOOT_PROTECT(1'b0)) u_a (
    .CLK(clk), .RST(rst), .EN(en), .RW(rw), .MAR_to_MEM(addr), .MDR_to_MEM(wdata),
    .MEM_to_MDR(rdata_a), .MFC(mfc_a), .ERR(err_a)
  );

  mem_sync_wait #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(0), .BOOT_PROTECT(1'b0)) u_b (
    .CLK(clk), .RST(rst), .EN(en), .RW(rw), .MAR_to_MEM(addr), .MDR_to_MEM(wdata),
    .MEM_to_MDR(rdata_b), .MFC(mfc_b), .ERR(err_b)
  );

  mem_sync_wait #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(2), .BOOT_PROTECT(1'b1)) u_c (
    .CLK(clk), .RST(rst), .EN(en), .RW(rw), .MAR_to_MEM(addr), .MDR_to_MEM(wdata),
    .MEM_to_MDR(rdata_c), .MFC(mfc_c), .ERR(err_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_mfc(input string tag, input logic ea, input logic eb, input logic ec);
    chk({tag, "_mfc_a"}, {15'd0, mfc_a}, {15'd0, ea});
    chk({tag, "_mfc_b"}, {15'd0, mfc_b}, {15'd0, eb});
    chk({tag, "_mfc_c"}, {15'd0, mfc_c}, {15'd0, ec});
  endtask

  task automatic chk3(input string tag, input logic [15:0] da, input logic [15:0] db,
                      input logic [15:0] dc, input logic ea, input logic eb, input logic ec);
    chk({tag, "_data_a"}, rdata_a, da);
    chk({tag, "_data_b"}, rdata_b, db);
    chk({tag, "_data_c"}, rdata_c, dc);
    chk({tag, "_err_a"}, {15'd0, err_a}, {15'd0, ea});
    chk({tag, "_err_b"}, {15'd0, err_b}, {15'd0, eb});
    chk({tag, "_err_c"}, {15'd0, err_c}, {15'd0, ec});
  endtask

  // Full handshake: capture, check MFC latency per variant, drop EN, check MFC release.
  // Inputs are scrambled after capture; the memories must use the captured values.
  task automatic access(input string tag, input logic r, input logic [15:0] a, input logic [15:0] d);
    en = 1'b1; rw = r; addr = a; wdata = d;
    @(posedge clk); #1;
    rw = ~r; addr = 16'h0005; wdata = 16'hDEAD;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk_mfc(tag, k >= 3, k >= 1, k >= 3);
    end
    en = 1'b0;
    @(posedge clk); #1;
    chk_mfc({tag, "_rel"}, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; rw = 1'b1; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_mfc("reset", 1'b0, 1'b0, 1'b0);
    chk3("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    access("rd3", 1'b1, 16'h0003, 16'h0000);
    chk3("rd3", 16'h5047, 16'h5047, 16'h5047, 1'b0, 1'b0, 1'b0);

    access("wr10", 1'b0, 16'h0010, 16'hABCD);
    chk3("wr10", 16'h5047, 16'h5047, 16'h5047, 1'b0, 1'b0, 1'b0);

    access("rd7", 1'b1, 16'h0007, 16'h0000);
    chk3("rd7", 16'hC042, 16'hC042, 16'hC042, 1'b0, 1'b0, 1'b0);

    access("rd10", 1'b1, 16'h0010, 16'h0000);
    chk3("rd10", 16'hABCD, 16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b0);

    access("rd100", 1'b1, 16'h0100, 16'h0000);
    chk3("rd100", 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1);

    access("rd10b", 1'b1, 16'h0010, 16'h0000);
    chk3("rd10b", 16'hABCD, 16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b0);

    access("wr1", 1'b0, 16'h0001, 16'h1234);
    chk3("wr1", 16'hABCD, 16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b1);

    access("rd1", 1'b1, 16'h0001, 16'h0000);
    chk3("rd1", 16'h1234, 16'h1234, 16'hF0FF, 1'b0, 1'b0, 1'b0);

    // Requester drops EN right after capture: write commits, MFC never rises
    en = 1'b1; rw = 1'b0; addr = 16'h0020; wdata = 16'h5555;
    @(posedge clk); #1;
    en = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk_mfc("early", 1'b0, 1'b0, 1'b0);
    end
    chk3("early", 16'h1234, 16'h1234, 16'hF0FF, 1'b0, 1'b0, 1'b0);

    access("rd20", 1'b1, 16'h0020, 16'h0000);
    chk3("rd20", 16'h5555, 16'h5555, 16'h5555, 1'b0, 1'b0, 1'b0);

    access("wr30", 1'b0, 16'h0030, 16'h0BAD);
    chk3("wr30", 16'h5555, 16'h5555, 16'h5555, 1'b0, 1'b0, 1'b0);

    access("wr0", 1'b0, 16'h0000, 16'h1111);
    chk3("wr0", 16'h5555, 16'h5555, 16'h5555, 1'b0, 1'b0, 1'b1);

    access("rd0", 1'b1, 16'h0000, 16'h0000);
    chk3("rd0", 16'h1111, 16'h1111, 16'h7002, 1'b0, 1'b0, 1'b0);

    // Reset lands one edge after capture of a write: access aborted, boot words reloaded
    en = 1'b1; rw = 1'b0; addr = 16'h0030; wdata = 16'h2222;
    @(posedge clk); #1;
    rst = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    chk_mfc("abort", 1'b0, 1'b0, 1'b0);
    chk3("abort", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    access("rd0r", 1'b1, 16'h0000, 16'h0000);
    chk3("rd0r", 16'h7002, 16'h7002, 16'h7002, 1'b0, 1'b0, 1'b0);

    access("rd30", 1'b1, 16'h0030, 16'h0000);
    chk3("rd30", 16'h0BAD, 16'h0BAD, 16'h0BAD, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
